// File: rtl/key_step_ctrl.sv
// rtl/key_step_ctrl.sv - debounced up/down/clear pushbutton stepper for a decade counter.
// Optional auto-repeat while a step key is held: define KEY_AUTO_REPEAT_EN.
module key_step_ctrl #(
  parameter int unsigned DEB_CYCLES    = 1000000,
  parameter int unsigned HOLD_CYCLES   = 25000000,
  parameter int unsigned REPEAT_CYCLES = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_up_n,
  input  logic key_dn_n,
  input  logic key_clr_n,
  output logic inc,
  output logic dec,
  output logic clr,
  output logic busy
);

  localparam int unsigned CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, PRESS_DEB, HELD, REL_DEB, LOCK} state_t;

  logic [2:0]    sync1, sync2;
  logic          up, dn, cl;
  logic          clr_armed, clr_fire;
  logic [CW-1:0] clr_cnt;
  state_t        state, state_nxt;
  logic          dir, dir_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          pulse, repeat_due;
  logic          lk, ot, cnt_last;

  // Bit order {clr, dn, up}; flops reset to 1 so a key held through reset reads as a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 3'b111;
      sync2 <= 3'b111;
    end else begin
      sync1 <= {key_clr_n, key_dn_n, key_up_n};
      sync2 <= sync1;
    end
  end

  assign up = ~sync2[0];
  assign dn = ~sync2[1];
  assign cl = ~sync2[2];

  // Clear debouncer alternates between waiting for a stable press and a stable release.
  assign clr_fire = clr_armed && cl && (clr_cnt == DEB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_armed <= 1'b1;
      clr_cnt   <= '0;
    end else if (clr_armed ? !cl : cl) begin
      clr_cnt <= '0;
    end else if (clr_cnt == DEB_LAST) begin
      clr_armed <= !clr_armed;
      clr_cnt   <= '0;
    end else begin
      clr_cnt <= clr_cnt + CW'(1);
    end
  end

  assign lk       = dir ? dn : up;
  assign ot       = dir ? up : dn;
  assign cnt_last = (cnt == DEB_LAST);

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    cnt_nxt   = cnt;
    pulse     = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (up && dn) begin
          state_nxt = LOCK;
        end else if (up || dn) begin
          state_nxt = PRESS_DEB;
          dir_nxt   = dn;
        end
      end
      PRESS_DEB: begin
        if (!lk || ot) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt_last) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          pulse     = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      HELD: begin
        cnt_nxt = '0;
        if (up && dn)         state_nxt = LOCK;
        else if (!lk)         state_nxt = REL_DEB;
        else if (repeat_due)  pulse     = 1'b1;
      end
      REL_DEB: begin
        if (lk) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt_last) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      LOCK: begin
        if (up || dn) begin
          cnt_nxt = '0;
        end else if (cnt_last) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // A clear wins over any step due in the same cycle and parks the stepper.
    if (clr_fire) begin
      state_nxt = LOCK;
      cnt_nxt   = '0;
      pulse     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dir   <= 1'b0;
      cnt   <= '0;
      inc   <= 1'b0;
      dec   <= 1'b0;
      clr   <= 1'b0;
    end else begin
      state <= state_nxt;
      dir   <= dir_nxt;
      cnt   <= cnt_nxt;
      inc   <= pulse & ~dir_nxt;
      dec   <= pulse & dir_nxt;
      clr   <= clr_fire;
    end
  end

  assign busy = (state != IDLE);

`ifdef KEY_AUTO_REPEAT_EN
  localparam int unsigned TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX);

  logic [TW-1:0] tmr;
  logic          rep;

  // Timer measures clocks since the last step pulse and keeps running through release bounces.
  assign repeat_due = tmr >= (rep ? TW'(REPEAT_CYCLES - 1) : TW'(HOLD_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
      rep <= 1'b0;
    end else if (pulse) begin
      tmr <= '0;
      rep <= (state == HELD);
    end else if ((state == HELD || state == REL_DEB) && tmr != TW'(TMAX - 1)) begin
      tmr <= tmr + TW'(1);
    end
  end
`else
  assign repeat_due = 1'b0;
`endif

endmodule

// File: doc/key_step_ctrl.md
KEY_STEP_CTRL -- requirements
Module: key_step_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 1000000: clocks a key level must remain stable to be accepted (20 ms at 50 MHz); legal range 2..2^24-1.
REQ-002 Parameter HOLD_CYCLES, default 25000000: clocks from the first step pulse to the first auto-repeat pulse; must be greater than DEB_CYCLES.
REQ-003 Parameter REPEAT_CYCLES, default 5000000: clocks between successive auto-repeat pulses; must be at least 2.
REQ-004 clk  input  1  system clock; all logic SHALL be on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 key_up_n  input  1  raw, asynchronous, active-low "up" pushbutton.
REQ-007 key_dn_n  input  1  raw, asynchronous, active-low "down" pushbutton.
REQ-008 key_clr_n  input  1  raw, asynchronous, active-low "clear" pushbutton.
REQ-009 inc  output  1  single-cycle step-up pulse, driving the decade counter's count-up enable.
REQ-010 dec  output  1  single-cycle step-down pulse, driving the decade counter's count-down enable.
REQ-011 clr  output  1  single-cycle clear pulse, driving the decade counter's synchronous clear.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 Each key SHALL pass through a two-flop synchronizer; all decisions SHALL use the synchronized level only.
REQ-014 inc, dec and clr SHALL be registered outputs, and at most one of them SHALL be high in any cycle.
REQ-015 The step FSM SHALL have exactly these states: IDLE, PRESS_DEB, HELD, REL_DEB and LOCK.
REQ-016 IDLE -> PRESS_DEB when exactly one of up/dn reads pressed; the direction SHALL be latched at this point; the debounce counter SHALL be cleared.
REQ-017 In PRESS_DEB, any cycle where the latched key reads released, or the other direction key reads pressed, SHALL return the FSM to IDLE with no pulse.
REQ-018 PRESS_DEB -> HELD after DEB_CYCLES consecutive pressed samples, issuing one inc or dec pulse; total latency SHALL be DEB_CYCLES+3 clocks from the raw falling edge.
REQ-019 In HELD, a released sample SHALL move the FSM to REL_DEB; REL_DEB SHALL return to IDLE after DEB_CYCLES consecutive released samples, and SHALL return to HELD on any pressed sample.
REQ-020 The hold/repeat timer SHALL keep running through a REL_DEB bounce that returns to HELD, and no pulse SHALL be issued while in REL_DEB.
REQ-021 If both up and dn read pressed in IDLE or HELD, the FSM SHALL enter LOCK and issue no pulses; LOCK -> IDLE only after both keys read released for DEB_CYCLES consecutive cycles.
REQ-022 The clear key SHALL have its own debouncer; DEB_CYCLES consecutive pressed samples SHALL produce one clr pulse per press, and a new press SHALL require a debounced release first.
REQ-023 A clr pulse SHALL have priority: an inc or dec due in the same cycle SHALL be dropped, and the step FSM SHALL go to LOCK.
REQ-024 Counters SHALL saturate and never wrap; counter widths SHALL be sized from the parameters.

Reset
REQ-025 On rst_n low: inc=0, dec=0, clr=0, busy=0, FSM in IDLE, all counters 0, synchronizer flops set to 1 (released).
REQ-026 Reset asserted mid-press SHALL abort the sequence with no pulse; a key still held at reset release SHALL be treated as a fresh press.

Configuration
REQ-027 Macro KEY_AUTO_REPEAT_EN, when defined: in HELD, a further pulse SHALL be issued HOLD_CYCLES clocks after the first pulse, then one every REPEAT_CYCLES clocks while the key stays held.
REQ-028 Without KEY_AUTO_REPEAT_EN: exactly one pulse per debounced press, and the hold/repeat timer SHALL not be implemented.

Verification (DEB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8)
REQ-029 key_up_n low at cycle 0, held for 10 clocks -> exactly one inc pulse, in cycle 7; dec and clr stay 0.
REQ-030 key_dn_n bounces low-high-low in 2-clock chunks, then stays low -> no dec pulse during the bounce; one dec pulse 7 clocks after the final falling edge.
REQ-031 key_up_n held for 60 clocks with KEY_AUTO_REPEAT_EN -> inc pulses in cycles 7, 27, 35, 43, 51 and 59; without the macro -> inc pulse in cycle 7 only.
REQ-032 key_up_n and key_dn_n pressed together -> no pulses and busy=1; up then released alone while dn stays held -> still no pulses until both are released for 4 clocks.
REQ-033 key_clr_n pressed while key_up_n is auto-repeating -> one clr pulse, no further inc pulses until key_up_n is released and pressed again.
REQ-034 rst_n pulsed low in cycle 5 of an up press -> no inc in cycle 7; inc in cycle 7 counted from reset release if the key is still held.
